// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one ALU between two requesters,
// with per-requester carry/borrow chains and a held response channel.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [3:0] req0_mode,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_mode,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_mode,
    output logic       alu_carry_f,
    output logic       alu_borrow_f,
    input  logic [3:0] alu_c,
    input  logic [3:0] alu_flags,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [3:0] rsp_c,
    output logic [3:0] rsp_flags,
    input  logic       rsp_ready
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic last, op_id, g1, any;
    logic [3:0] op_mode, op_a, op_b;
    logic [1:0] carry, borrow;

    // last holds the id granted most recently; a tie goes to the other one
    assign g1 = req1_valid & (~req0_valid | ~last);
    assign any = req0_valid | req1_valid;

    always_comb begin
        state_nx = (state == IDLE) ? (any ? EXEC : IDLE) :
                   (state == EXEC) ? RESP : (rsp_ready ? IDLE : RESP);
        req0_ready = rst_n & (state == IDLE) & req0_valid & ~g1;
        req1_ready = rst_n & (state == IDLE) & g1;
        rsp_valid = state == RESP;
    end

    assign alu_a = op_a;
    assign alu_b = op_b;
    assign alu_mode = op_mode;
    assign alu_carry_f = carry[op_id];
    assign alu_borrow_f = borrow[op_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last <= 1'b1;
            op_id <= 1'b0;
            op_mode <= '0;
            op_a <= '0;
            op_b <= '0;
            carry <= '0;
            borrow <= '0;
            rsp_id <= 1'b0;
            rsp_c <= '0;
            rsp_flags <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any) begin
                op_mode <= g1 ? req1_mode : req0_mode;
                op_a <= g1 ? req1_a : req0_a;
                op_b <= g1 ? req1_b : req0_b;
                op_id <= g1;
                last <= g1;
            end
            if (state == EXEC) begin
                rsp_c <= alu_c;
                rsp_flags <= alu_flags;
                rsp_id <= op_id;
                if (op_mode == 4'b0001) carry[op_id] <= alu_flags[0];
                if (op_mode == 4'b0011) borrow[op_id] <= alu_flags[1];
            end
        end
    end
endmodule
